// File: rtl/logic_op_pkg.sv
// logic_op_pipe shared types: op encodings and the bitwise op helper.
// Operands are widened to MAX_W so one function serves every WIDTH.
package logic_op_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  function automatic word_t apply_op(
    input word_t a,
    input word_t b,
    input op_e   op
  );
    word_t r;
    r = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_PASS: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_stage.sv
// One valid/data register slice of the logic_op_pipe pipeline.
// Loads when empty or when its consumer takes the held beat.
module logic_op_stage
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined bitwise op unit with optional fold-accumulate operand.
// Stage 1 captures the op result; later stages are plain slices.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_comb
);

  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];

  logic [WIDTH-1:0] acc;
  logic             acc_live;
  logic             fold;
  logic             accept;
  word_t            a_w;
  word_t            b_w;
  word_t            r_w;
  word_t            c_w;
  logic             unused_hi;

  assign fold   = (ACC_EN != 0) && in_acc;
  assign accept = in_valid && in_ready;

  assign a_w = word_t'(in_a);
  assign b_w = fold ? word_t'(acc)
                    : word_t'(in_b);
  assign r_w = apply_op(a_w, b_w, op_e'(in_op));
  assign c_w = apply_op(a_w, word_t'(in_b),
                        op_e'(in_op));

  // First fold beat of a sequence seeds with A.
  assign dat[0] = (fold && !acc_live)
                ? in_a : r_w[WIDTH-1:0];
  assign vld[0] = in_valid;

  assign out_comb  = c_w[WIDTH-1:0];
  assign unused_hi = ^{r_w, c_w};

  generate
    if (ACC_EN != 0) begin : g_acc
      always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
          acc      <= '0;
          acc_live <= 1'b0;
        end else if (accept) begin
          if (fold) begin
            acc      <= dat[0];
            acc_live <= 1'b1;
          end
          if (in_last) acc_live <= 1'b0;
        end
      end
    end else begin : g_noacc
      logic unused_last;
      assign acc         = '0;
      assign acc_live    = 1'b0;
      assign unused_last = in_last;
    end
  endgenerate

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stg
      logic_op_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .areset   (areset),
        .in_valid (vld[k]),
        .in_ready (rdy[k]),
        .in_data  (dat[k]),
        .out_valid(vld[k+1]),
        .out_ready(rdy[k+1]),
        .out_data (dat[k+1])
      );
    end
  endgenerate

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[STAGES];
  assign out_result  = dat[STAGES];
  assign out_zero    = (dat[STAGES] == '0);

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: three configurations,
// directed vectors, per-DUT expected queues popped by monitors.
module tb_logic_op_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // main: WIDTH=8 STAGES=3 ACC_EN=1
  logic       m_iv, m_ir, m_acc, m_last;
  logic       m_ov, m_or, m_zero;
  logic [7:0] m_a, m_b, m_res, m_comb;
  logic [2:0] m_op;
  logic [7:0] q_m [$];

  logic_op_pipe #(
    .WIDTH(8), .STAGES(3), .ACC_EN(1)
  ) u_m (
    .clk(clk), .areset(areset),
    .in_valid(m_iv), .in_ready(m_ir),
    .in_a(m_a), .in_b(m_b), .in_op(m_op),
    .in_acc(m_acc), .in_last(m_last),
    .out_valid(m_ov), .out_ready(m_or),
    .out_result(m_res), .out_zero(m_zero),
    .out_comb(m_comb)
  );

  // small: WIDTH=1 STAGES=1
  logic       s_iv, s_ir, s_ov, s_or, s_zero;
  logic [0:0] s_a, s_b, s_res, s_comb;
  logic [2:0] s_op;
  logic       q_s [$];

  logic_op_pipe #(
    .WIDTH(1), .STAGES(1), .ACC_EN(1)
  ) u_s (
    .clk(clk), .areset(areset),
    .in_valid(s_iv), .in_ready(s_ir),
    .in_a(s_a), .in_b(s_b), .in_op(s_op),
    .in_acc(1'b0), .in_last(1'b0),
    .out_valid(s_ov), .out_ready(s_or),
    .out_result(s_res), .out_zero(s_zero),
    .out_comb(s_comb)
  );

  // no accumulator: WIDTH=8 STAGES=1 ACC_EN=0
  logic       n_iv, n_ir, n_acc, n_last;
  logic       n_ov, n_or, n_zero;
  logic [7:0] n_a, n_b, n_res, n_comb;
  logic [2:0] n_op;
  logic [7:0] q_n [$];

  logic_op_pipe #(
    .WIDTH(8), .STAGES(1), .ACC_EN(0)
  ) u_n (
    .clk(clk), .areset(areset),
    .in_valid(n_iv), .in_ready(n_ir),
    .in_a(n_a), .in_b(n_b), .in_op(n_op),
    .in_acc(n_acc), .in_last(n_last),
    .out_valid(n_ov), .out_ready(n_or),
    .out_result(n_res), .out_zero(n_zero),
    .out_comb(n_comb)
  );

  always @(negedge clk) begin
    logic [7:0] e;
    if (!areset && m_ov && m_or) begin
      if (q_m.size() == 0) chk("m_extra", 1, 0);
      else begin
        e = q_m.pop_front();
        chk("m_result", m_res, e);
        chk("m_zero", m_zero, e == 8'h00);
      end
    end
  end

  always @(negedge clk) begin
    logic e;
    if (!areset && s_ov && s_or) begin
      if (q_s.size() == 0) chk("s_extra", 1, 0);
      else begin
        e = q_s.pop_front();
        chk("s_result", s_res, e);
        chk("s_zero", s_zero, !e);
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!areset && n_ov && n_or) begin
      if (q_n.size() == 0) chk("n_extra", 1, 0);
      else begin
        e = q_n.pop_front();
        chk("n_result", n_res, e);
      end
    end
  end

  task automatic send_m(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [2:0] op,
                        input logic acc,
                        input logic last,
                        input logic [7:0] exp);
    int t = 0;
    m_iv = 1'b1; m_a = a; m_b = b;
    m_op = op; m_acc = acc; m_last = last;
    @(negedge clk);
    if (!acc) chk("m_comb", m_comb, exp);
    while (!m_ir && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!m_ir) chk("m_accept_timeout", 0, 1);
    else q_m.push_back(exp);
    @(posedge clk);
    #1;
    m_iv = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_m.size() + q_s.size() + q_n.size()) != 0
           && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  logic [3:0] tt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    // truth tables, bit index = {a,b}
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
           4'b0001, 4'b1001, 4'b0100, 4'b1100};
    areset = 1'b1;
    m_iv = 0; m_a = 0; m_b = 0; m_op = 0;
    m_acc = 0; m_last = 0; m_or = 1;
    s_iv = 0; s_a = 0; s_b = 0; s_op = 0; s_or = 1;
    n_iv = 0; n_a = 0; n_b = 0; n_op = 0;
    n_acc = 0; n_last = 0; n_or = 1;
    #1;
    chk("rst_valid", m_ov, 0);
    chk("rst_result", m_res, 0);
    chk("rst_zero", m_zero, 1);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;

    // streaming and latency
    send_m(8'h0F, 8'hF0, 3'd0, 0, 0, 8'h00);
    send_m(8'hFF, 8'h3C, 3'd0, 0, 0, 8'h3C);
    @(negedge clk);
    chk("lat_early", m_ov, 0);
    @(negedge clk);
    chk("lat_hit", m_ov, 1);
    drain();

    // backpressure
    m_or = 1'b0;
    send_m(8'hAA, 8'h0F, 3'd0, 0, 0, 8'h0A);
    send_m(8'h50, 8'h05, 3'd1, 0, 0, 8'h55);
    send_m(8'hF0, 8'h0F, 3'd5, 0, 0, 8'h00);
    m_iv = 1'b1; m_a = 8'h12; m_op = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", m_ir, 0);
      chk("bp_valid", m_ov, 1);
      chk("bp_hold", m_res, 8'h0A);
    end
    @(posedge clk);
    #1;
    m_or = 1'b1;
    send_m(8'h12, 8'h00, 3'd7, 0, 0, 8'h12);
    send_m(8'hFF, 8'h0F, 3'd6, 0, 0, 8'hF0);
    send_m(8'hFF, 8'h0F, 3'd3, 0, 0, 8'hF0);
    send_m(8'h0F, 8'h0F, 3'd4, 0, 0, 8'hF0);
    drain();

    // fold XOR
    send_m(8'h11, 8'hFF, 3'd2, 1, 0, 8'h11);
    send_m(8'h22, 8'hFF, 3'd2, 1, 0, 8'h33);
    send_m(8'h44, 8'hFF, 3'd2, 1, 1, 8'h77);
    send_m(8'h05, 8'hFF, 3'd2, 1, 0, 8'h05);
    send_m(8'h0F, 8'hFF, 3'd0, 0, 0, 8'h0F);
    send_m(8'h30, 8'hFF, 3'd2, 1, 1, 8'h35);
    send_m(8'h06, 8'hFF, 3'd0, 1, 1, 8'h06);
    drain();

    // reset mid-stream
    m_or = 1'b0;
    send_m(8'h33, 8'h00, 3'd1, 1, 0, 8'h33);
    send_m(8'h01, 8'h02, 3'd1, 0, 0, 8'h03);
    #2;
    areset = 1'b1;
    #1;
    chk("mid_rst_valid", m_ov, 0);
    chk("mid_rst_zero", m_zero, 1);
    q_m.delete();
    @(posedge clk);
    #1;
    areset = 1'b0;
    m_or = 1'b1;
    send_m(8'hA5, 8'h5A, 3'd2, 1, 1, 8'hA5);
    drain();

    // WIDTH=1 sweep
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        s_iv = 1'b1;
        s_a = ab[1];
        s_b = ab[0];
        s_op = op[2:0];
        #1;
        chk("s_comb", s_comb, tt[op][ab]);
        @(negedge clk);
        if (!s_ir) chk("s_ready", 0, 1);
        else q_s.push_back(tt[op][ab]);
        @(posedge clk);
        #1;
      end
    end
    s_iv = 1'b0;
    drain();

    // ACC_EN=0 takes B from in_b
    n_iv = 1'b1; n_acc = 1'b1; n_last = 1'b1;
    n_op = 3'd1; n_a = 8'h01; n_b = 8'h80;
    #1;
    chk("n_comb", n_comb, 8'h81);
    @(negedge clk);
    if (!n_ir) chk("n_ready", 0, 1);
    else q_n.push_back(8'h81);
    @(posedge clk);
    #1;
    n_iv = 1'b0;
    drain();

    chk("queues_drained",
        q_m.size() + q_s.size() + q_n.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
